// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - bit-serial subtractor, one full-subtractor cell, LSB first (optional SERIAL_SUB_OVF_EN)
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             bout,
    output logic             ovf
`else
    output logic             bout
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             br;

    logic             x_bit;
    logic             y_bit;
    logic             d_bit;
    logic             br_nxt;
    logic             last_bit;

    // Full-subtractor cell on the bit currently selected by the counter
    always_comb begin
        x_bit    = a_r[cnt];
        y_bit    = b_r[cnt];
        d_bit    = x_bit ^ y_bit ^ br;
        br_nxt   = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & br);
        last_bit = (cnt == CW'(WIDTH - 1));
    end

    // The borrow register doubles as the final borrow-out once DONE is reached
    assign bout = br;

    // Control FSM plus the serial datapath; reset abandons any operation in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            a_r   <= '0;
            b_r   <= '0;
            br    <= 1'b0;
            diff  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        br    <= bin;
                        cnt   <= '0;
                        diff  <= '0;
                        busy  <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                        ovf   <= 1'b0;
`endif
                        state <= RUN;
                    end
                end
                RUN: begin
                    diff[cnt] <= d_bit;
                    br        <= br_nxt;
                    cnt       <= cnt + 1'b1;
                    if (last_bit) begin
`ifdef SERIAL_SUB_OVF_EN
                        ovf   <= (a_r[WIDTH-1] ^ b_r[WIDTH-1]) & (a_r[WIDTH-1] ^ d_bit);
`endif
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb/tb_serial_sub_ctrl.sv - scoreboard bench for serial_sub_ctrl
module tb_serial_sub_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
`ifdef SERIAL_SUB_OVF_EN
        .bout  (bout),
        .ovf   (ovf)
`else
        .bout  (bout)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
        exp_t        e;
        logic [W:0]  r;
        r    = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
        e.d  = r[W-1:0];
        e.bo = r[W];
        e.ov = (x[W-1] ^ y[W-1]) & (x[W-1] ^ r[W-1]);
        return e;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("diff", {24'd0, diff}, {24'd0, e.d});
                check("bout", {31'd0, bout}, {31'd0, e.bo});
`ifdef SERIAL_SUB_OVF_EN
                check("ovf", {31'd0, ovf}, {31'd0, e.ov});
`endif
            end
        end
    end

    // Called at a negedge with the DUT idle; returns just after the accepting edge
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi, input bit push);
        a     = x;
        b     = y;
        bin   = bi;
        start = 1'b1;
        if (push) sb.push_back(model(x, y, bi));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts edges after accept until done is seen, and negedges with busy high
    task automatic wait_done(output int edges, output int busy_n);
        edges  = 0;
        busy_n = 0;
        forever begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done || edges > 200) break;
            @(posedge clk);
            edges++;
        end
        if (!done) check("done_timeout", {31'd0, done}, 32'd1);
    endtask

    logic [W-1:0] tab_a [10] = '{8'h05, 8'h03, 8'h00, 8'h80, 8'h7F, 8'hFF, 8'h00, 8'h01, 8'hC3, 8'h40};
    logic [W-1:0] tab_b [10] = '{8'h03, 8'h05, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h3C, 8'hC0};
    logic         tab_c [10] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0};

    initial begin
        int  edges;
        int  busy_n;
        int  cyc;
        int  ndone;
        int  last_done;
        bit  saw_done;

        rst_n = 1'b0;
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h55;
        bin   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_diff", {24'd0, diff}, 32'd0);
        check("rst_bout", {31'd0, bout}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf", {31'd0, ovf}, 32'd0);
`endif

        // First edge out of reset with start high must accept
        rst_n = 1'b1;
        issue(8'h05, 8'h03, 1'b0, 1'b1);
        wait_done(edges, busy_n);
        check("latency_edges", edges, W);
        check("busy_cycles", busy_n, W + 1);
        @(negedge clk);
        check("busy_after", {31'd0, busy}, 32'd0);
        check("hold_diff", {24'd0, diff}, 32'h02);

        // Operand table plus random operands
        for (int i = 0; i < 16; i++) begin
            if (i < 10) issue(tab_a[i], tab_b[i], tab_c[i], 1'b1);
            else        issue(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
            wait_done(edges, busy_n);
            check("tab_latency", edges, W);
            @(negedge clk);
        end

        // Reset while bit 4 is due: abandon, no done pulse
        issue(8'hA5, 8'h17, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_diff", {24'd0, diff}, 32'd0);
        check("abort_bout", {31'd0, bout}, 32'd0);
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", {31'd0, saw_done}, 32'd0);
        issue(8'h10, 8'h20, 1'b0, 1'b1);
        wait_done(edges, busy_n);
        check("post_abort_latency", edges, W);
        @(negedge clk);

        // Start during RUN ignored; operands scrambled after accept
        issue(8'h5A, 8'h33, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        a     = 8'hFF;
        b     = 8'h00;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (done || cyc > 50) break;
            a   = W'($urandom);
            b   = W'($urandom);
            bin = 1'($urandom);
            cyc++;
        end
        check("ignore_done_seen", {31'd0, done}, 32'd1);
        repeat (2) begin
            @(negedge clk);
            check("ignore_no_requeue", {31'd0, busy}, 32'd0);
        end

        // Start held high: back-to-back operations every W+2 cycles
        a     = 8'h9C;
        b     = 8'h27;
        bin   = 1'b0;
        start = 1'b1;
        repeat (3) sb.push_back(model(8'h9C, 8'h27, 1'b0));
        cyc       = 0;
        ndone     = 0;
        last_done = 0;
        while (ndone < 3 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                if (ndone > 0) check("done_interval", cyc - last_done, W + 2);
                last_done = cyc;
                ndone++;
                if (ndone == 3) start = 1'b0;
            end
        end
        check("held_done_count", ndone, 3);
        repeat (3) @(negedge clk);
        check("held_stopped", {31'd0, busy}, 32'd0);

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
